// File: rtl/sound_arbiter_if.sv
// Bundle between sound_arbiter, its three note requesters and the buzzer engine.
// master: the arbiter side. slave: requesters plus engine (also used by the bench).
interface sound_arbiter_if #(
  parameter int OCT_W  = 3,
  parameter int NOTE_W = 3,
  parameter int LEN_W  = 3
);
  logic                en;
  logic [2:0]          req_valid;
  logic [3*OCT_W-1:0]  req_octave;
  logic [3*NOTE_W-1:0] req_note;
  logic [3*LEN_W-1:0]  req_length;
  logic [2:0]          req_ack;
  logic [2:0]          req_done;
  logic                snd_busy;
  logic                snd_start;
  logic [OCT_W-1:0]    snd_octave;
  logic [NOTE_W-1:0]   snd_note;
  logic [LEN_W-1:0]    snd_length;
  logic [1:0]          owner;
  logic                err_timeout;

  modport master (
    input  en, req_valid, req_octave, req_note, req_length, snd_busy,
    output req_ack, req_done, snd_start, snd_octave, snd_note, snd_length,
           owner, err_timeout
  );

  modport slave (
    output en, req_valid, req_octave, req_note, req_length, snd_busy,
    input  req_ack, req_done, snd_start, snd_octave, snd_note, snd_length,
           owner, err_timeout
  );
endinterface

// File: rtl/sound_arbiter.sv
// sound_arbiter: round-robin sharing of the single buzzer engine between
// free-play keys (req 0), song autoplay (req 1) and the play-mode hit path (req 2).
// Optional feature macro: SOUND_ARB_GAP_EN inserts GAP_CYCLES of silence after
// every completed note.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no note owned; round-robin pick among valid requesters
// ST_START | snd_start held high, waiting for engine busy (timeout guarded)
// ST_PLAY  | engine playing; wait for busy to fall, then pulse done
// ST_GAP   | silence after a note, owner held (SOUND_ARB_GAP_EN only)
module sound_arbiter #(
  parameter int OCT_W         = 3,
  parameter int NOTE_W        = 3,
  parameter int LEN_W         = 3,
  parameter int START_TIMEOUT = 255,
  parameter int GAP_CYCLES    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sound_arbiter_if.master  bus
);

  if (START_TIMEOUT < 1 || START_TIMEOUT > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 255)
  begin : g_bad_param
    $error("sound_arbiter: START_TIMEOUT and GAP_CYCLES must be within 1..255");
  end

`ifdef SOUND_ARB_GAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_PLAY, ST_GAP} state_t;
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_PLAY} state_t;
`endif

  localparam logic [7:0] TMO_LAST   = 8'(START_TIMEOUT - 1);
  localparam logic [1:0] OWNER_NONE = 2'd3;

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          owner_q, owner_d;
  logic [2:0]          ack_q, ack_d;
  logic [2:0]          done_q, done_d;
  logic                start_q, start_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                err_q, err_d;
  logic [7:0]          tmo_q, tmo_d;
`ifdef SOUND_ARB_GAP_EN
  logic [7:0]          gap_q, gap_d;
`endif

  logic                win_found;
  logic [1:0]          win_idx;
  logic [1:0]          cand;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin winner, searching from last+1 modulo 3.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = rr_next(cand);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    ack_d   = 3'b000;
    done_d  = 3'b000;
    start_d = start_q;
    oct_d   = oct_q;
    note_d  = note_q;
    len_d   = len_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
`ifdef SOUND_ARB_GAP_EN
    gap_d   = gap_q;
`endif

    if (!bus.en) begin
      // Abort: no ack/done for the dropped note, last and snd_* keep their values.
      state_d = ST_IDLE;
      owner_d = OWNER_NONE;
      start_d = 1'b0;
      tmo_d   = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          owner_d = OWNER_NONE;
          start_d = 1'b0;
          if (win_found) begin
            oct_d   = bus.req_octave[win_idx*OCT_W +: OCT_W];
            note_d  = bus.req_note[win_idx*NOTE_W +: NOTE_W];
            len_d   = bus.req_length[win_idx*LEN_W +: LEN_W];
            ack_d   = 3'b001 << win_idx;
            owner_d = win_idx;
            last_d  = win_idx;
            start_d = 1'b1;
            tmo_d   = 8'd0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (bus.snd_busy) begin
            start_d = 1'b0;
            tmo_d   = 8'd0;
            state_d = ST_PLAY;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            done_d  = 3'b001 << owner_q;
            start_d = 1'b0;
            tmo_d   = 8'd0;
            owner_d = OWNER_NONE;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        ST_PLAY: begin
          start_d = 1'b0;
          if (!bus.snd_busy) begin
            done_d = 3'b001 << owner_q;
`ifdef SOUND_ARB_GAP_EN
            gap_d   = 8'd0;
            state_d = ST_GAP;
`else
            owner_d = OWNER_NONE;
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef SOUND_ARB_GAP_EN
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            owner_d = OWNER_NONE;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
`endif
        default: begin
          owner_d = OWNER_NONE;
          start_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; last resets to 2 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd2;
      owner_q <= OWNER_NONE;
      ack_q   <= 3'b000;
      done_q  <= 3'b000;
      start_q <= 1'b0;
      oct_q   <= '0;
      note_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 8'd0;
`ifdef SOUND_ARB_GAP_EN
      gap_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      start_q <= start_d;
      oct_q   <= oct_d;
      note_q  <= note_d;
      len_q   <= len_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`ifdef SOUND_ARB_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.req_done    = done_q;
  assign bus.snd_start   = start_q;
  assign bus.snd_octave  = oct_q;
  assign bus.snd_note    = note_q;
  assign bus.snd_length  = len_q;
  assign bus.owner       = owner_q;
  assign bus.err_timeout = err_q;

endmodule
